// File: rtl/ibus_if.sv
// ibus_if: instruction fetch over an AHB-Lite read bus into a halfword buffer feeding stage 0.
// Define IBUS_IF_BYPASS_EN to present returning bus data on the outputs in the same cycle when the buffer is empty.
module ibus_if #(
  parameter int BUF_HW = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  input  logic        instr_fetch,
  input  logic [1:0]  instr_fetch_size,
  output logic [1:0]  instr_vld_size,
  output logic [31:0] instr,
  output logic        instr_contains_fault,
  output logic [31:0] haddr,
  output logic        hprot,
  output logic [1:0]  hsize,
  output logic [31:0] hwdata,
  output logic        htrans,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready
);
  localparam int CW = $clog2(BUF_HW + 3);
  logic [15:0]   bd [BUF_HW];
  logic          bf [BUF_HW];
  logic [15:0]   ed [BUF_HW+2];
  logic          ef [BUF_HW+2];
  logic [CW-1:0] occ, npush, ecnt, vcnt, pop;
  logic          en, drop, dphase, discard, cap, jmp_unused;
  assign hprot      = 1'b0;
  assign hsize      = 2'b10;
  assign hwdata     = '0;
  assign jmp_unused = jmp_addr[0];
  assign cap    = dphase & hready & ~discard & ~jmp_req;
  // stop issuing as soon as an error response starts so nothing past the faulting word goes out
  assign htrans = en & ~jmp_req & ~(dphase & hresp) & (int'(occ) + (dphase ? 4 : 2) <= BUF_HW);
  assign npush  = cap ? (drop ? CW'(1) : CW'(2)) : '0;
  assign ecnt   = occ + npush;
`ifdef IBUS_IF_BYPASS_EN
  assign vcnt = (occ == '0) ? ecnt : occ;
`else
  assign vcnt = occ;
`endif
  // ed: buffer contents followed by this cycle's returned halfwords, zero beyond
  for (genvar g = 0; g < BUF_HW + 2; g++) begin : g_ext
    if (g < BUF_HW) begin : g_b
      assign ed[g] = (CW'(g) < occ) ? bd[g] : (CW'(g) < ecnt) ? ((CW'(g) == occ && !drop) ? hrdata[15:0] : hrdata[31:16]) : '0;
      assign ef[g] = (CW'(g) < occ) ? bf[g] : (CW'(g) < ecnt) & hresp;
    end else begin : g_z
      assign ed[g] = '0;
      assign ef[g] = 1'b0;
    end
  end
  assign instr_vld_size       = jmp_req ? 2'b00 : (vcnt >= CW'(2)) ? 2'b10 : (vcnt == CW'(1)) ? 2'b01 : 2'b00;
  assign instr                = {instr_vld_size[1] ? ed[1] : 16'h0, (instr_vld_size != 2'b00) ? ed[0] : 16'h0};
  assign instr_contains_fault = ((instr_vld_size != 2'b00) & ef[0]) | (instr_vld_size[1] & ef[1]);
  assign pop = (jmp_req | ~instr_fetch) ? '0 : (instr_fetch_size[1] & instr_vld_size[1]) ? CW'(2) : (instr_vld_size != 2'b00) ? CW'(1) : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ     <= '0;
      en      <= 1'b0;
      drop    <= 1'b0;
      dphase  <= 1'b0;
      discard <= 1'b0;
      haddr   <= '0;
      for (int i = 0; i < BUF_HW; i++) begin
        bd[i] <= '0;
        bf[i] <= 1'b0;
      end
    end else begin
      dphase  <= hready ? htrans : dphase;
      haddr   <= jmp_req ? {jmp_addr[31:2], 2'b00} : (htrans & hready) ? haddr + 32'd4 : haddr;
      en      <= jmp_req | (en & ~(cap & hresp));
      drop    <= jmp_req ? jmp_addr[1] : drop & ~cap;
      discard <= jmp_req ? dphase & ~hready : discard & ~hready;
      occ     <= jmp_req ? '0 : ecnt - pop;
      for (int i = 0; i < BUF_HW; i++) begin
        bd[i] <= (pop == CW'(2)) ? ed[i+2] : (pop == CW'(1)) ? ed[i+1] : ed[i];
        bf[i] <= (pop == CW'(2)) ? ef[i+2] : (pop == CW'(1)) ? ef[i+1] : ef[i];
      end
    end
  end
endmodule

// File: tb/tb_ibus_if.sv
// tb_ibus_if: directed bench for ibus_if with an AHB-Lite read slave returning {a+3,a+2,a+1,a},
// able to stretch a data phase (wait_st) or answer a chosen address with a two-cycle error.
`timescale 1ns/1ps
module tb_ibus_if;
  logic        clk = 0, rstn = 0, jmp_req = 0, instr_fetch = 0;
  logic [31:0] jmp_addr = 0;
  logic [1:0]  instr_fetch_size = 2'b01;
  logic [1:0]  instr_vld_size, hsize;
  logic [31:0] instr, haddr, hwdata, hrdata;
  logic        instr_contains_fault, hprot, htrans, hresp, hready;
  logic        dp_v, err2, err_hit;
  logic        wait_st = 0, err_en = 0, mon_en = 0;
  logic [31:0] dp_a, err_addr = 32'h40;
  int          n_vec = 0, n_err = 0, n_acc = 0, bad_iss = 0;
  logic [31:0] acc_q[$];
  logic [31:0] got[$];
  logic        gotf[$];

  always #5 clk = ~clk;

  ibus_if dut (
    .clk(clk), .rstn(rstn), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .instr_fetch(instr_fetch), .instr_fetch_size(instr_fetch_size),
    .instr_vld_size(instr_vld_size), .instr(instr), .instr_contains_fault(instr_contains_fault),
    .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwdata(hwdata), .htrans(htrans),
    .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  assign err_hit = err_en && dp_v && dp_a == err_addr;
  assign hready  = !(err_hit && !err2) && !wait_st;
  assign hresp   = err_hit;
  assign hrdata  = {dp_a[7:0] + 8'd3, dp_a[7:0] + 8'd2, dp_a[7:0] + 8'd1, dp_a[7:0]};

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      dp_v <= 0; dp_a <= 0; err2 <= 0;
    end else begin
      err2 <= err_hit && !err2;
      if (hready) begin dp_v <= htrans; dp_a <= haddr; end
      if (htrans && hready) begin
        n_acc <= n_acc + 1;
        acc_q.push_back(haddr);
        if (mon_en && haddr > 32'h40) bad_iss <= bad_iss + 1;
      end
    end

  function automatic logic [15:0] hw(input int base, input int k);
    logic [7:0] b;
    b = 8'(base + 2 * k);
    return {b + 8'd1, b};
  endfunction

  function automatic logic [31:0] pw(input int base, input int j);
    return {hw(base, 2 * j + 1), hw(base, 2 * j)};
  endfunction

  task automatic do_jump(input logic [31:0] a);
    jmp_req = 1; jmp_addr = a; #1;
    n_vec++; if (instr_vld_size !== 2'b00) begin n_err++; $display("FAIL jmp_vld got=%b exp=00", instr_vld_size); end
    n_vec++; if (htrans !== 1'b0) begin n_err++; $display("FAIL jmp_htrans got=%b exp=0", htrans); end
    @(negedge clk); jmp_req = 0; #1;
  endtask

  task automatic consume(input bit wide, input int n, input int budget);
    int c = 0;
    got.delete(); gotf.delete();
    instr_fetch_size = wide ? 2'b10 : 2'b01;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      instr_fetch = 0;
      if (wide ? instr_vld_size == 2'b10 : instr_vld_size != 2'b00) begin
        instr_fetch = 1;
        got.push_back(wide ? instr : {16'h0, instr[15:0]});
        gotf.push_back(instr_contains_fault);
      end
      c++;
    end
    @(negedge clk); instr_fetch = 0;
    n_vec++; if (got.size() != n) begin n_err++; $display("FAIL consume_count got=%0d exp=%0d", got.size(), n); end
  endtask

  task automatic test_reset;
    rstn = 0; repeat (3) @(negedge clk); #1;
    n_vec++; if (htrans !== 1'b0) begin n_err++; $display("FAIL rst_htrans got=%b exp=0", htrans); end
    n_vec++; if (haddr !== 32'h0) begin n_err++; $display("FAIL rst_haddr got=%h exp=0", haddr); end
    n_vec++; if (instr_vld_size !== 2'b00) begin n_err++; $display("FAIL rst_vld got=%b exp=00", instr_vld_size); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", instr); end
    n_vec++; if (instr_contains_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got=%b exp=0", instr_contains_fault); end
    n_vec++; if ({hprot, hsize, hwdata} !== {1'b0, 2'b10, 32'h0}) begin n_err++; $display("FAIL rst_const got=%b/%b/%h exp=0/10/0", hprot, hsize, hwdata); end
    rstn = 1; repeat (3) @(negedge clk); #1;
    n_vec++; if (htrans !== 1'b0) begin n_err++; $display("FAIL idle_htrans got=%b exp=0", htrans); end
  endtask

  task automatic test_latency_32;
    @(negedge clk); acc_q.delete();
    do_jump(32'h2);
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL t1_addr got=%b/%h exp=1/0", htrans, haddr); end
    @(negedge clk); #1;
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL t2_addr got=%b/%h exp=1/4", htrans, haddr); end
    @(negedge clk); #1;
    n_vec++; if (instr_vld_size !== 2'b01) begin n_err++; $display("FAIL t3_vld got=%b exp=01", instr_vld_size); end
    n_vec++; if (instr !== 32'h0000_0302) begin n_err++; $display("FAIL t3_instr got=%h exp=00000302", instr); end
    consume(1, 6, 60);
    for (int j = 0; j < got.size(); j++) begin
      n_vec++; if (got[j] !== pw(2, j) || gotf[j] !== 1'b0) begin n_err++; $display("FAIL w32_parcel%0d got=%h/%b exp=%h/0", j, got[j], gotf[j], pw(2, j)); end
    end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      n_vec++; if (acc_q[i] !== 32'(4 * i)) begin n_err++; $display("FAIL w32_haddr%0d got=%h exp=%h", i, acc_q[i], 4 * i); end
    end
  endtask

  task automatic test_16bit;
    @(negedge clk);
    do_jump(32'h2);
    consume(0, 8, 60);
    for (int k = 0; k < got.size(); k++) begin
      n_vec++; if (got[k] !== {16'h0, hw(2, k)} || gotf[k] !== 1'b0) begin n_err++; $display("FAIL h16_parcel%0d got=%h/%b exp=%h/0", k, got[k], gotf[k], hw(2, k)); end
    end
  endtask

  task automatic test_stall;
    int n0;
    @(negedge clk); n0 = n_acc;
    do_jump(32'h0);
    repeat (20) @(negedge clk); #1;
    n_vec++; if (n_acc - n0 != 3) begin n_err++; $display("FAIL stall_words got=%0d exp=3", n_acc - n0); end
    n_vec++; if (htrans !== 1'b0) begin n_err++; $display("FAIL stall_htrans got=%b exp=0", htrans); end
    n_vec++; if ({instr_vld_size, instr} !== {2'b10, 32'h0302_0100}) begin n_err++; $display("FAIL stall_head got=%b/%h exp=10/03020100", instr_vld_size, instr); end
    instr_fetch = 1; instr_fetch_size = 2'b10;
    @(negedge clk); instr_fetch = 0; #1;
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'hc}) begin n_err++; $display("FAIL stall_resume got=%b/%h exp=1/c", htrans, haddr); end
    consume(0, 6, 60);
    for (int k = 0; k < got.size(); k++) begin
      n_vec++; if (got[k] !== {16'h0, hw(4, k)}) begin n_err++; $display("FAIL stall_parcel%0d got=%h exp=%h", k, got[k], hw(4, k)); end
    end
  endtask

  task automatic test_error;
    @(negedge clk); err_en = 1;
    do_jump(32'h38);
    mon_en = 1;
    consume(1, 3, 60);
    for (int j = 0; j < got.size(); j++) begin
      n_vec++; if (got[j] !== pw(32'h38, j) || gotf[j] !== (j == 2)) begin n_err++; $display("FAIL err_parcel%0d got=%h/%b exp=%h/%0d", j, got[j], gotf[j], pw(32'h38, j), j == 2); end
    end
    repeat (10) @(negedge clk); #1;
    n_vec++; if (bad_iss != 0) begin n_err++; $display("FAIL err_beyond got=%0d exp=0", bad_iss); end
    n_vec++; if ({htrans, instr_vld_size} !== 3'b000) begin n_err++; $display("FAIL err_idle got=%b/%b exp=0/00", htrans, instr_vld_size); end
    mon_en = 0; err_en = 0;
  endtask

  task automatic test_jump_inflight;
    @(negedge clk);
    do_jump(32'h80);
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL jif_t1 got=%b/%h exp=1/80", htrans, haddr); end
    @(negedge clk); wait_st = 1; #1;
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'h84}) begin n_err++; $display("FAIL jif_hold got=%b/%h exp=1/84", htrans, haddr); end
    @(negedge clk);
    do_jump(32'h2);
    n_vec++; if ({htrans, haddr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL jif_restart got=%b/%h exp=1/0", htrans, haddr); end
    repeat (2) @(negedge clk);
    wait_st = 0;
    consume(1, 3, 60);
    for (int j = 0; j < got.size(); j++) begin
      n_vec++; if (got[j] !== pw(2, j) || gotf[j] !== 1'b0) begin n_err++; $display("FAIL jif_parcel%0d got=%h/%b exp=%h/0", j, got[j], gotf[j], pw(2, j)); end
    end
  endtask

  task automatic test_async_reset;
    int n0;
    @(negedge clk);
    do_jump(32'h0);
    repeat (6) @(negedge clk); #1;
    n_vec++; if (instr_vld_size !== 2'b10) begin n_err++; $display("FAIL arst_pre got=%b exp=10", instr_vld_size); end
    #1; rstn = 0; #1;
    n_vec++; if ({htrans, haddr} !== 33'h0) begin n_err++; $display("FAIL arst_bus got=%b/%h exp=0/0", htrans, haddr); end
    n_vec++; if ({instr_vld_size, instr, instr_contains_fault} !== 35'h0) begin n_err++; $display("FAIL arst_out got=%b/%h/%b exp=00/0/0", instr_vld_size, instr, instr_contains_fault); end
    @(negedge clk); rstn = 1; n0 = n_acc;
    repeat (5) @(negedge clk); #1;
    n_vec++; if (htrans !== 1'b0 || n_acc != n0) begin n_err++; $display("FAIL arst_idle got=%b/%0d exp=0/0", htrans, n_acc - n0); end
  endtask

  initial begin
    test_reset();
    test_latency_32();
    test_16bit();
    test_stall();
    test_error();
    test_jump_inflight();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
